// File: rtl/baud_controller.sv
// -----------------------------------------------------------------------------
// baud_controller
// Sequences a host request to change the UART baud rate. The new rate is
// loaded only after TX and RX are idle. A frame is never cut short by a rate
// change. After the load strobe, the block waits for the generator to produce
// SETTLE_EDGES qualified rising edges. Only then does it report the new rate
// as in effect.
//
// Ports
//   i_clk              system clock, all logic on its rising edge
//   i_rst_n            asynchronous active-low reset
//   i_req              host request to change rate (sampled only in IDLE)
//   i_req_select[3:0]  requested rate code, 0=9600 .. 9=1500000
//   o_ack              one-cycle pulse that ends every request
//   o_err              qualifies o_ack: 1 = rejected or aborted
//   o_busy             high in every state except IDLE
//   i_tx_busy          transmitter has a frame in flight
//   i_rx_busy          receiver has a frame in flight
//   o_hold             tells TX/RX not to start new frames
//   o_baud_select[3:0] rate code driven to the baud generator
//   o_update_baud      one-cycle load strobe to the baud generator
//   i_baud_rising_edge rising-edge pulse from the baud generator
//   o_current_select[3:0] rate code currently in effect
// -----------------------------------------------------------------------------
module baud_controller #(
    parameter int unsigned SETTLE_EDGES  = 2,
    parameter int unsigned DRAIN_TIMEOUT = 1_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req,
    input  logic [3:0] i_req_select,
    output logic       o_ack,
    output logic       o_err,
    output logic       o_busy,
    input  logic       i_tx_busy,
    input  logic       i_rx_busy,
    output logic       o_hold,
    output logic [3:0] o_baud_select,
    output logic       o_update_baud,
    input  logic       i_baud_rising_edge,
    output logic [3:0] o_current_select
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_UPDATE = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [3:0]  LP_MAX_CODE   = 4'd9;
    // The counter is compared against the last count value, so the abort
    // lands after exactly DRAIN_TIMEOUT cycles spent in DRAIN.
    localparam logic [31:0] LP_DRAIN_LAST = 32'(DRAIN_TIMEOUT - 1);
    localparam logic [7:0]  LP_EDGE_LAST  = 8'(SETTLE_EDGES - 1);
    // This is the number of SETTLE cycles in which generator edges are
    // ignored. These cycles cover the generator's load latency.
    localparam logic [1:0]  LP_BLANK      = 2'd2;

    // A rate code is legal when it names one of the ten supported rates.
    function automatic logic f_code_valid(input logic [3:0] code);
        return (code <= LP_MAX_CODE);
    endfunction

    state_t      r_state;
    logic [3:0]  r_pending;
    logic [31:0] r_drain_cnt;
    logic [7:0]  r_edge_cnt;
    logic [1:0]  r_blank_cnt;
    logic        r_ack;
    logic        r_err;
    logic        r_busy;
    logic        r_hold;
    logic        r_update_baud;
    logic [3:0]  r_baud_select;
    logic [3:0]  r_current_select;

    state_t      w_state_next;
    logic [3:0]  w_pending_next;
    logic [31:0] w_drain_next;
    logic [7:0]  w_edge_next;
    logic [1:0]  w_blank_next;
    logic        w_ack_next;
    logic        w_err_next;
    logic [3:0]  w_baud_select_next;
    logic [3:0]  w_current_next;

    // Next-state logic, plus the next value of every registered output and counter.
    always_comb begin
        w_state_next       = r_state;
        w_pending_next     = r_pending;
        w_drain_next       = r_drain_cnt;
        w_edge_next        = r_edge_cnt;
        w_blank_next       = r_blank_cnt;
        w_ack_next         = 1'b0;
        w_err_next         = 1'b0;
        w_baud_select_next = r_baud_select;
        w_current_next     = r_current_select;

        case (r_state)
            ST_IDLE: begin
                if (i_req) begin
                    if (!f_code_valid(i_req_select)) begin
                        w_ack_next = 1'b1;
                        w_err_next = 1'b1;
                    end else if (i_req_select == r_current_select) begin
                        w_ack_next = 1'b1;
                    end else begin
                        w_pending_next = i_req_select;
                        w_drain_next   = 32'd0;
                        w_state_next   = ST_DRAIN;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end

            ST_DRAIN: begin
                if (!i_tx_busy && !i_rx_busy) begin
                    // Present the code together with the strobe in UPDATE.
                    w_baud_select_next = r_pending;
                    w_state_next       = ST_UPDATE;
                end else if (r_drain_cnt == LP_DRAIN_LAST) begin
                    w_ack_next   = 1'b1;
                    w_err_next   = 1'b1;
                    w_state_next = ST_DONE;
                end else begin
                    w_drain_next = r_drain_cnt + 32'd1;
                end
            end

            ST_UPDATE: begin
                w_edge_next  = 8'd0;
                w_blank_next = 2'd0;
                w_state_next = ST_SETTLE;
            end

            ST_SETTLE: begin
                if (r_blank_cnt < LP_BLANK) begin
                    w_blank_next = r_blank_cnt + 2'd1;
                end else if (i_baud_rising_edge) begin
                    if (r_edge_cnt == LP_EDGE_LAST) begin
                        w_ack_next     = 1'b1;
                        w_current_next = r_pending;
                        w_state_next   = ST_DONE;
                    end else begin
                        w_edge_next = r_edge_cnt + 8'd1;
                    end
                end else begin
                    w_state_next = ST_SETTLE;
                end
            end

            ST_DONE: begin
                w_state_next = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register and registered outputs. Outputs are decoded from the next state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state          <= ST_IDLE;
            r_pending        <= 4'd0;
            r_drain_cnt      <= 32'd0;
            r_edge_cnt       <= 8'd0;
            r_blank_cnt      <= 2'd0;
            r_ack            <= 1'b0;
            r_err            <= 1'b0;
            r_busy           <= 1'b0;
            r_hold           <= 1'b0;
            r_update_baud    <= 1'b0;
            r_baud_select    <= 4'd0;
            r_current_select <= 4'd0;
        end else begin
            r_state          <= w_state_next;
            r_pending        <= w_pending_next;
            r_drain_cnt      <= w_drain_next;
            r_edge_cnt       <= w_edge_next;
            r_blank_cnt      <= w_blank_next;
            r_ack            <= w_ack_next;
            r_err            <= w_err_next;
            r_busy           <= (w_state_next != ST_IDLE);
            r_hold           <= (w_state_next != ST_IDLE);
            r_update_baud    <= (w_state_next == ST_UPDATE);
            r_baud_select    <= w_baud_select_next;
            r_current_select <= w_current_next;
        end
    end

    assign o_ack            = r_ack;
    assign o_err            = r_err;
    assign o_busy           = r_busy;
    assign o_hold           = r_hold;
    assign o_update_baud    = r_update_baud;
    assign o_baud_select    = r_baud_select;
    assign o_current_select = r_current_select;

endmodule

// File: tb/tb_baud_controller.sv
// -----------------------------------------------------------------------------
// tb_baud_controller
// Scoreboard bench for baud_controller. Each request pushes the expected
// err flag and the expected rate in effect at acknowledge time. A negedge
// monitor pops an entry on every o_ack and compares it with the DUT outputs.
// Inputs change on the falling edge. The DUT samples them on the next rising edge.
// -----------------------------------------------------------------------------
module tb_baud_controller;

    localparam int unsigned DRAIN_TO = 64;
    localparam int unsigned SETTLE_N = 2;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic [3:0] req_select;
    logic       ack;
    logic       err;
    logic       busy;
    logic       tx_busy;
    logic       rx_busy;
    logic       hold;
    logic [3:0] baud_select;
    logic       update_baud;
    logic       baud_edge;
    logic [3:0] current_select;

    typedef struct {
        logic       err;
        logic [3:0] cur;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks;
    int         n_errors;
    int         ack_cnt;
    int         upd_cnt;
    logic [3:0] last_bsel;
    logic       edge_auto;

    baud_controller #(
        .SETTLE_EDGES (SETTLE_N),
        .DRAIN_TIMEOUT(DRAIN_TO)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_req             (req),
        .i_req_select      (req_select),
        .o_ack             (ack),
        .o_err             (err),
        .o_busy            (busy),
        .i_tx_busy         (tx_busy),
        .i_rx_busy         (rx_busy),
        .o_hold            (hold),
        .o_baud_select     (baud_select),
        .o_update_baud     (update_baud),
        .i_baud_rising_edge(baud_edge),
        .o_current_select  (current_select)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard monitor: pops one expectation per acknowledge and tracks load strobes.
    always @(negedge clk) begin
        if (rst_n) begin
            if (update_baud) begin
                upd_cnt++;
                last_bsel = baud_select;
            end
            if (ack) begin
                ack_cnt++;
                if (exp_q.size() == 0) begin
                    check("ack_has_expectation", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("ack_err", {31'd0, err}, {31'd0, e.err});
                    check("ack_current_select", {28'd0, current_select}, {28'd0, e.cur});
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        baud_edge = edge_auto;
    endtask

    // Drive a one-cycle request and record its expected outcome.
    task automatic send_req(input logic [3:0] sel, input logic e_err, input logic [3:0] e_cur);
        exp_t e;
        e.err = e_err;
        e.cur = e_cur;
        exp_q.push_back(e);
        req        = 1'b1;
        req_select = sel;
        step();
        req = 1'b0;
    endtask

    // Step until o_ack is seen or the budget runs out; count cycles with o_hold low.
    task automatic wait_ack(input int max, output bit seen, output int cycles, output int hold_low);
        seen     = 1'b0;
        cycles   = 0;
        hold_low = 0;
        for (int i = 0; i < max; i++) begin
            step();
            cycles++;
            if (!hold) hold_low++;
            if (ack) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_upd(input int max, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max; i++) begin
            step();
            if (update_baud) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit         seen;
        int         cycles;
        int         hold_low;
        int         upd0;
        int         ack0;
        logic [9:0] pat;

        n_checks   = 0;
        n_errors   = 0;
        ack_cnt    = 0;
        upd_cnt    = 0;
        last_bsel  = 4'd0;
        edge_auto  = 1'b0;
        rst_n      = 1'b0;
        req        = 1'b0;
        req_select = 4'd0;
        tx_busy    = 1'b0;
        rx_busy    = 1'b0;
        baud_edge  = 1'b0;

        // Reset values
        step();
        step();
        check("reset_outputs",
              {19'd0, ack, err, busy, hold, update_baud, baud_select, current_select}, 32'd0);
        rst_n = 1'b1;
        step();

        // Select 4 with idle TX/RX: two edges in the blanking window are ignored.
        send_req(4'd4, 1'b0, 4'd4);
        check("t1_hold_after_accept", {31'd0, hold}, 32'd1);
        pat = 10'b0101011100;
        for (int c = 2; c <= 9; c++) begin
            edge_auto = pat[c];
            step();
            if (c == 2) begin
                check("t1_update_strobe", {31'd0, update_baud}, 32'd1);
                check("t1_baud_select", {28'd0, baud_select}, 32'd4);
            end
            if (c == 7) check("t1_no_early_ack", {31'd0, ack}, 32'd0);
            if (c == 9) check("t1_ack_after_2nd_edge", {31'd0, ack}, 32'd1);
        end
        edge_auto = 1'b0;
        step();
        check("t1_hold_released", {30'd0, hold, busy}, 32'd0);
        check("t1_current_select", {28'd0, current_select}, 32'd4);
        check("t1_single_update", 32'(upd_cnt), 32'd1);

        // An invalid code is rejected on the next cycle, with no hold and no update.
        upd0 = upd_cnt;
        send_req(4'd12, 1'b1, 4'd4);
        check("t2_reject_ack", {30'd0, ack, err}, 32'd3);
        check("t2_no_hold", {31'd0, hold}, 32'd0);
        step();
        check("t2_no_update", 32'(upd_cnt), 32'(upd0));

        // A request for the code already in effect is acknowledged without an update.
        send_req(4'd4, 1'b0, 4'd4);
        check("t3_same_ack", {30'd0, ack, err}, 32'd2);
        step();
        check("t3_no_update", 32'(upd_cnt), 32'(upd0));

        // TX busy for 50 cycles: the load waits for it and hold stays high.
        tx_busy = 1'b1;
        step();
        send_req(4'd7, 1'b0, 4'd7);
        hold_low = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (!hold) hold_low++;
        end
        check("t4_no_update_while_busy", 32'(upd_cnt), 32'(upd0));
        tx_busy   = 1'b0;
        edge_auto = 1'b1;
        wait_ack(40, seen, cycles, cycles);
        hold_low += cycles;
        check("t4_ack_seen", {31'd0, seen}, 32'd1);
        check("t4_hold_continuous", 32'(hold_low), 32'd0);
        check("t4_update_once", 32'(upd_cnt), 32'(upd0 + 1));
        check("t4_baud_select", {28'd0, last_bsel}, 32'd7);
        edge_auto = 1'b0;
        step();

        // RX stays busy: abort after DRAIN_TO drain cycles and keep the current rate.
        upd0    = upd_cnt;
        rx_busy = 1'b1;
        send_req(4'd9, 1'b1, 4'd7);
        wait_ack(DRAIN_TO + 10, seen, cycles, hold_low);
        check("t5_timeout_ack", {31'd0, seen}, 32'd1);
        check("t5_timeout_cycles", 32'(cycles), 32'(DRAIN_TO));
        check("t5_no_update", 32'(upd_cnt), 32'(upd0));
        step();
        check("t5_hold_drops", {31'd0, hold}, 32'd0);
        check("t5_current_kept", {28'd0, current_select}, 32'd7);
        rx_busy = 1'b0;

        // A second request during SETTLE is ignored and produces exactly one ack.
        ack0 = ack_cnt;
        send_req(4'd2, 1'b0, 4'd2);
        wait_upd(10, seen);
        check("t6_update_seen", {31'd0, seen}, 32'd1);
        step();
        req        = 1'b1;
        req_select = 4'd5;
        step();
        req       = 1'b0;
        edge_auto = 1'b1;
        wait_ack(20, seen, cycles, hold_low);
        check("t6_ack_seen", {31'd0, seen}, 32'd1);
        for (int i = 0; i < 10; i++) step();
        check("t6_single_ack", 32'(ack_cnt - ack0), 32'd1);
        check("t6_current_select", {28'd0, current_select}, 32'd2);

        // Back-to-back requests: a held i_req is sampled again in the first IDLE cycle after DONE.
        exp_q.push_back('{err: 1'b0, cur: 4'd3});
        exp_q.push_back('{err: 1'b0, cur: 4'd3});
        req        = 1'b1;
        req_select = 4'd3;
        wait_ack(20, seen, cycles, hold_low);
        check("t7_first_ack", {31'd0, seen}, 32'd1);
        step();
        step();
        check("t7_resampled_ack", {31'd0, ack}, 32'd1);
        req = 1'b0;
        step();
        check("t7_idle_after", {30'd0, ack, busy}, 32'd0);
        check("t7_queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset asserted during SETTLE clears outputs immediately; no ack follows.
        edge_auto = 1'b0;
        send_req(4'd6, 1'b0, 4'd6);
        wait_upd(10, seen);
        check("t8_update_seen", {31'd0, seen}, 32'd1);
        step();
        ack0 = ack_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        check("t8_async_reset_outputs",
              {19'd0, ack, err, busy, hold, update_baud, baud_select, current_select}, 32'd0);
        exp_q.delete();
        step();
        rst_n     = 1'b1;
        edge_auto = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check("t8_no_ack_after_reset", 32'(ack_cnt - ack0), 32'd0);
        check("t8_current_reset", {28'd0, current_select}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time guard in case a wait slips past its cycle budget.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
